// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the x^5 + x^3 + 1 PN stream: self-synchronises,
// flywheels once locked, and counts bit errors and valid bits for BER measurement.
module lfsr_seq_checker #(
    parameter int LOCK_CNT = 10,
    parameter int LOSS_THR = 8,
    parameter int ERR_W    = 16,
    parameter int BIT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [4:0] LOCK_C   = 5'(LOCK_CNT);
    localparam logic [4:0] LOSS_C   = 5'(LOSS_THR);
    localparam logic [4:0] WIN_LAST = 5'd30;
    localparam logic [2:0] FILL_LEN = 3'd5;

    state_t             state, state_n;
    logic [4:0]         hist, hist_n;
    logic [2:0]         fill_cnt, fill_n;
    logic [4:0]         match_cnt, match_n;
    logic [4:0]         win_cnt, win_cnt_n;
    logic [4:0]         win_err, win_err_n;
    logic [ERR_W-1:0]   err_n;
    logic [BIT_W-1:0]   bit_n;
    logic               pulse_n;
    logic               predicted;
    logic               mismatch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_n;
            match_cnt <= match_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_cnt   <= err_n;
            bit_cnt   <= bit_n;
            err_pulse <= pulse_n;
            locked    <= (state_n == LOCKED);
        end
    end

    // s[n] = s[n-5] ^ s[n-3]; hist[0] is the newest bit
    assign predicted = hist[4] ^ hist[2];
    assign mismatch  = din ^ predicted;

    always_comb begin
        state_n   = state;
        hist_n    = hist;
        fill_n    = fill_cnt;
        match_n   = match_cnt;
        win_cnt_n = win_cnt;
        win_err_n = win_err;
        err_n     = err_cnt;
        bit_n     = bit_cnt;
        pulse_n   = 1'b0;

        if (din_vld) begin
            case (state)
                SEARCH: begin
                    hist_n = {hist[3:0], din};
                    if (fill_cnt != FILL_LEN) begin
                        fill_n = fill_cnt + 3'd1;
                    end else if (!mismatch && (hist != '0)) begin
                        if ((match_cnt + 5'd1) == LOCK_C) begin
                            state_n   = LOCKED;
                            match_n   = '0;
                            win_cnt_n = '0;
                            win_err_n = '0;
                        end else begin
                            match_n = match_cnt + 5'd1;
                        end
                    end else begin
                        match_n = '0;
                    end
                end

                LOCKED: begin
                    // flywheel: the prediction, not the received bit, feeds history
                    hist_n = {hist[3:0], predicted};
                    if (bit_cnt != '1) begin
                        bit_n = bit_cnt + 1'b1;
                    end
                    if (mismatch) begin
                        pulse_n   = 1'b1;
                        win_err_n = win_err + 5'd1;
                        if (err_cnt != '1) begin
                            err_n = err_cnt + 1'b1;
                        end
                    end
                    if (mismatch && ((win_err + 5'd1) >= LOSS_C)) begin
                        state_n = SEARCH;
                        fill_n  = '0;
                        match_n = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + 5'd1;
                    end
                end

                default: begin
                    state_n = SEARCH;
                end
            endcase
        end

        if (clr) begin
            err_n = '0;
            bit_n = '0;
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: table of stream scenarios with a per-cycle
// expectation queue, plus async-reset and narrow-counter saturation checks.
module tb_lfsr_seq_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic        din_vld = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        locked2, err_pulse2;
    logic [1:0]  err_cnt2;
    logic [31:0] bit_cnt2;

    lfsr_seq_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    lfsr_seq_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .bit_cnt(bit_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nbits;
        bit gap;
        int stuck;      // 0 none, 1 stuck-at-0, 2 stuck-at-1
        int e_first, e_step, e_num, e_period, e_reps;
        int clr_at;
        int lock_at, loss_at, relock_at;
        int f_err, f_bit, f_pulses;
        bit f_locked;
        int f_err2;
    } vec_t;

    typedef struct {
        bit locked;
        bit pulse;
        int err;
        int bits;
    } exp_t;

    int   pn [31] = '{1,1,1,1,1,0,0,0,1,1,0,1,1,1,0,1,0,1,0,0,0,0,1,0,0,1,0,1,1,0,0};
    exp_t exp_q [$];
    exp_t mon_e;
    vec_t vt [9];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   obs_pulses = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int nbits, bit gap, int stuck, int ef, int es, int en,
                                int ep, int er, int clr_at, int lk, int ls, int rl,
                                int fe, int fb, int fp, bit fl, int fe2);
        vec_t v;
        v.nbits = nbits; v.gap = gap; v.stuck = stuck;
        v.e_first = ef; v.e_step = es; v.e_num = en; v.e_period = ep; v.e_reps = er;
        v.clr_at = clr_at; v.lock_at = lk; v.loss_at = ls; v.relock_at = rl;
        v.f_err = fe; v.f_bit = fb; v.f_pulses = fp; v.f_locked = fl; v.f_err2 = fe2;
        return v;
    endfunction

    function automatic bit is_err(vec_t v, int i);
        for (int r = 0; r < v.e_reps; r++)
            for (int k = 0; k < v.e_num; k++)
                if (i == v.e_first + r * v.e_period + k * v.e_step) return 1'b1;
        return 1'b0;
    endfunction

    // expected lock state after valid bit i has been consumed
    function automatic bit locked_after(vec_t v, int i);
        bit l;
        if (v.lock_at == 0 || i < v.lock_at) return 1'b0;
        l = 1'b1;
        if (v.loss_at != 0 && i >= v.loss_at)
            l = (v.relock_at != 0 && i >= v.relock_at);
        return l;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("locked", locked, mon_e.locked);
            check("err_pulse", err_pulse, mon_e.pulse);
            check("err_cnt", err_cnt, mon_e.err);
            check("bit_cnt", bit_cnt, mon_e.bits);
            if (err_pulse) obs_pulses++;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; din_vld = 1'b0; clr = 1'b0; din = 1'b0;
        #2;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input bit do_reset);
        int   i, cyc, exp_err, exp_bit;
        bit   vld, d, c, pulse;
        exp_t e;
        if (do_reset) apply_reset();
        i = 0; cyc = 0; exp_err = 0; exp_bit = 0; obs_pulses = 0;
        while (i < v.nbits) begin
            @(negedge clk);
            vld = v.gap ? (cyc % 2 == 0) : 1'b1;
            cyc++;
            pulse = 1'b0;
            c = 1'b0;
            if (vld) begin
                i++;
                if (v.stuck == 1)      d = 1'b0;
                else if (v.stuck == 2) d = 1'b1;
                else                   d = pn[(i - 1) % 31][0] ^ is_err(v, i);
                c = (i == v.clr_at);
                if (locked_after(v, i - 1)) begin
                    exp_bit++;
                    if (is_err(v, i)) begin
                        exp_err++;
                        pulse = 1'b1;
                    end
                end
                if (c) begin
                    exp_err = 0;
                    exp_bit = 0;
                end
            end else begin
                d = 1'($urandom_range(1, 0));
            end
            din = d; din_vld = vld; clr = c;
            e.locked = locked_after(v, i);
            e.pulse  = pulse;
            e.err    = exp_err;
            e.bits   = exp_bit;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        din_vld = 1'b0; clr = 1'b0;
        check("q_drained", exp_q.size(), 0);
        check("final_err_cnt", err_cnt, v.f_err);
        check("final_bit_cnt", bit_cnt, v.f_bit);
        check("final_pulses", obs_pulses, v.f_pulses);
        check("final_locked", locked, v.f_locked);
        check("final_err_cnt_w2", err_cnt2, v.f_err2);
    endtask

    initial begin
        vec_t v;
        //        nbits gap stk ef es en ep er clr lk  ls  rl  ferr fbit fp fl fe2
        vt[0] = mk(100, 0, 0,  0, 0, 0, 0, 0,  0, 15,  0,  0,   0,  85,  0, 1, 0); // clean
        vt[1] = mk( 60, 0, 0, 40, 0, 1, 0, 1,  0, 15,  0,  0,   1,  45,  1, 1, 1); // single err
        vt[2] = mk( 70, 0, 0, 20, 2, 8, 0, 1,  0, 15, 34, 49,   8,  40,  8, 1, 3); // burst, relock
        vt[3] = mk(175, 0, 0, 16, 4, 7,31, 5,  0, 15,  0,  0,  35, 160, 35, 1, 3); // 7 per window
        vt[4] = mk(200, 0, 1,  0, 0, 0, 0, 0,  0,  0,  0,  0,   0,   0,  0, 0, 0); // stuck 0
        vt[5] = mk(200, 0, 2,  0, 0, 0, 0, 0,  0,  0,  0,  0,   0,   0,  0, 0, 0); // stuck 1
        vt[6] = mk( 50, 1, 0,  0, 0, 0, 0, 0,  0, 15,  0,  0,   0,  35,  0, 1, 0); // gapped
        vt[7] = mk( 40, 0, 0, 31, 0, 1, 0, 1, 31, 15,  0,  0,   0,   9,  1, 1, 0); // clr on error
        vt[8] = mk( 60, 0, 0, 20, 3, 5, 0, 1,  0, 15,  0,  0,   5,  45,  5, 1, 3); // 5 errs, sat w2

        for (int n = 0; n < 9; n++) run_vec(vt[n], 1'b1);

        // asynchronous reset while locked with a pulse outstanding
        v = mk(30, 0, 0, 30, 0, 1, 0, 1, 0, 15, 0, 0, 1, 15, 1, 1, 1);
        run_vec(v, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("async_locked", locked, 0);
        check("async_err_pulse", err_pulse, 0);
        check("async_err_cnt", err_cnt, 0);
        check("async_bit_cnt", bit_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        v = mk(20, 0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 5, 0, 1, 0);
        run_vec(v, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Receive-side checker for the 5-bit pseudonoise stream (x^5 + x^3 + 1, period 31, seed 11111) driven by the team's PN generator. It consumes one serial bit per qualified clock, self-synchronises to the sequence phase, declares lock, then counts bit errors and valid bits for link BER measurement on the DAC8820 evaluation interface. It also drops lock when the error density becomes too high.

## Interface
- LOCK_CNT, 10: consecutive correct predictions required in SEARCH to declare lock (1..31).
- LOSS_THR, 8: mismatches within one 31-bit window that force loss of lock (1..31).
- ERR_W, 16: width of err_cnt.
- BIT_W, 32: width of bit_cnt.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  received serial PN bit.
- din_vld  in  1  din qualifier; state advances only on edges where it is 1.
- clr  in  1  synchronous clear of err_cnt and bit_cnt.
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected while LOCKED.
- err_cnt  out  ERR_W  saturating mismatch count, LOCKED only.
- bit_cnt  out  BIT_W  saturating count of valid bits evaluated while LOCKED.

## Operation
- **History register.**
  - hist[4:0] holds the last five bits; hist[0] is the newest.
  - predicted = hist[4] ^ hist[2], which implements s[n] = s[n-5] ^ s[n-3].
  - The register shifts left on every valid bit.
- **SEARCH state (entered on reset).**
  - The first 5 valid bits fill hist; no comparison is made. A fill counter counts 0..5.
  - From the 6th valid bit on, din is shifted in and compared with predicted.
  - The match counter increments when din == predicted and hist != 0. Otherwise it clears to 0.
  - The hist != 0 guard means stuck-at-0 input never locks.
  - When the match counter reaches LOCK_CNT, the state goes to LOCKED. The window counter and window error counter clear.
- **LOCKED state (flywheel).**
  - predicted, not din, is shifted into hist, so one channel error counts exactly once.
  - Every valid bit increments bit_cnt.
  - When din != predicted: err_cnt increments, window error count increments, and err_pulse = 1 on the next cycle.
  - The window counter runs 0..30. After evaluating the bit at count 30 it wraps to 0 and clears the window error count.
- **Loss of lock.**
  - Triggered when the window error count including the current bit reaches LOSS_THR.
  - State goes to SEARCH; fill and match counters clear. hist is kept but refilled (5 fill bits before comparison).
  - The triggering error is still counted in err_cnt and pulsed.
  - Loss takes priority over a window wrap on the same bit.
- **Counters.**
  - err_cnt and bit_cnt saturate at all-ones.
  - clr = 1 forces both to 0 on that edge, overriding any simultaneous increment.
  - clr does not affect state, hist or lock.
- **din_vld = 0.** All state and counters hold, and err_pulse = 0.

## Timing
- All outputs are registered.
- Reset values: locked = 0, err_pulse = 0, err_cnt = 0, bit_cnt = 0. Internally: hist = 0, state = SEARCH, all internal counters 0.
- Reset acts asynchronously, including mid-lock; outputs go to 0 without waiting for a clock edge.
- Lock latency for a clean stream with continuous din_vld and default LOCK_CNT:
  - locked rises after the edge sampling the 15th valid bit (5 fill + 10 matches).
  - bit_cnt starts with the 16th valid bit.
- err_pulse and the err_cnt update appear on the cycle after the edge that samples the bad bit.
- locked falls on the same edge that registers the LOSS_THR-th window error.
- Relock after loss takes at least 5 + LOCK_CNT further valid bits.
- No throughput limit: one bit per clock is supported.

## Test plan
- **Clean stream.** From reset, feed the generator sequence (1 1 1 1 1 0 0 0 1 1 0 1 1 1 0 1 0 1 0 0 0 0 1 0 0 1 0 1 1 0 0, repeating) with din_vld = 1 for 100 bits.
  - locked rises after edge 15.
  - After 100 bits: err_cnt = 0, bit_cnt = 85, err_pulse never asserted.
- **Single error after lock.** Invert one bit.
  - Exactly one err_pulse; err_cnt = 1.
  - locked stays 1 and no follow-on errors occur.
- **Error burst.** Invert 8 bits within one 31-bit window.
  - locked falls on the 8th error edge; err_cnt = 8.
  - Clean data afterwards relocks after 15 more valid bits.
  - 7 errors per window repeated for 5 windows keeps lock; err_cnt = 35.
- **Stuck inputs.**
  - din stuck at 0 for 200 bits: locked never asserts.
  - din stuck at 1 for 200 bits: locked never asserts (every prediction is 0).
- **Gapped input.** Clean stream with din_vld toggling 1,0,1,0.
  - locked rises after the 15th valid bit (edge 29).
  - Counters do not move on din_vld = 0 cycles.
- **Clear, reset and saturation.**
  - Assert clr on the same cycle as a mismatch: err_cnt = 0 afterwards and locked is unchanged.
  - Drop rst mid-lock: all outputs 0 immediately and lock latency repeats.
  - With ERR_W = 2, 5 errors give err_cnt = 3.
